// File: rtl/conv_pkg.sv
// Shared widths, FSM encoding, weight-register indices and saturation limits
// for the 2x2 window multiply-accumulate block.
package conv_pkg;

  localparam int DATA_W   = 32;
  localparam int FRAC_DEF = 16;
  localparam int PROD_W   = 2 * DATA_W;
  // Four products plus the shifted bias need three guard bits.
  localparam int ACC_W    = PROD_W + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [2:0] IDX_K1   = 3'd0;
  localparam logic [2:0] IDX_K2   = 3'd1;
  localparam logic [2:0] IDX_K3   = 3'd2;
  localparam logic [2:0] IDX_K4   = 3'd3;
  localparam logic [2:0] IDX_BIAS = 3'd4;

  localparam logic signed [DATA_W-1:0] SAT_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [DATA_W-1:0] SAT_MIN = 32'sh8000_0000;

  function automatic logic signed [PROD_W-1:0] smul(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [PROD_W-1:0] ax;
    logic signed [PROD_W-1:0] bx;
    ax = PROD_W'(a);
    bx = PROD_W'(b);
    return ax * bx;
  endfunction

endpackage

// File: rtl/q_sat_shift.sv
// Rescales a wide fixed-point accumulator back to the data format: arithmetic
// right shift (floor) followed by saturation to the signed 32-bit range.
module q_sat_shift
  import conv_pkg::*;
#(
  parameter int FRAC = FRAC_DEF
) (
  input  logic signed [ACC_W-1:0]  din,
  output logic signed [DATA_W-1:0] dout
);

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = din >>> FRAC;
    if (shifted > ACC_W'(SAT_MAX)) begin
      dout = SAT_MAX;
    end else if (shifted < ACC_W'(SAT_MIN)) begin
      dout = SAT_MIN;
    end else begin
      dout = shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/conv2x2_window_mac.sv
// 2x2 convolution over a streamed window: frame-position FSM, weight/bias
// registers and a fixed 3-stage multiply / accumulate / rescale pipeline.
module conv2x2_window_mac
  import conv_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              lf_done,
  input  logic [DATA_W-1:0] w1,
  input  logic [DATA_W-1:0] w2,
  input  logic [DATA_W-1:0] w3,
  input  logic [DATA_W-1:0] w4,
  input  logic              wt_valid,
  input  logic [2:0]        wt_idx,
  input  logic [DATA_W-1:0] wt_data,
  output logic              wt_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              frame_done,
  output state_t            state
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic signed [DATA_W-1:0] k [4];
  logic signed [DATA_W-1:0] bias;
  logic                     issue;
  logic                     issue_last;
  logic                     v1, v2, v3;
  logic                     l1, l2;
  logic signed [PROD_W-1:0] p [4];
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] sat;

  assign wt_ready   = (state == IDLE);
  // Column 0 windows straddle two rows and are never issued.
  assign issue      = (state == RUN) && enable && (col != '0);
  assign issue_last = issue && (row == ROW_LAST) && (col == COL_LAST);
  assign out_valid  = v3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
    end else begin
      case (state)
        IDLE: if (enable) state <= FILL;
        // The window arriving with lf_done is (1,0); the next one is (1,1).
        FILL: if (enable && lf_done) begin
          state <= RUN;
          row   <= ROW_W'(1);
          col   <= COL_W'(1);
        end
        RUN: if (enable) begin
          if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST) state <= DRAIN;
            else                 row   <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        DRAIN: if (!v1 && !v2 && !v3) begin
          state <= IDLE;
          row   <= '0;
          col   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) k[i] <= '0;
      bias <= '0;
    end else if (wt_valid && wt_ready) begin
      case (wt_idx)
        IDX_K1:   k[0] <= wt_data;
        IDX_K2:   k[1] <= wt_data;
        IDX_K3:   k[2] <= wt_data;
        IDX_K4:   k[3] <= wt_data;
        IDX_BIAS: bias <= wt_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      l1         <= 1'b0;
      l2         <= 1'b0;
      for (int i = 0; i < 4; i++) p[i] <= '0;
      acc        <= '0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      v1         <= issue;
      l1         <= issue_last;
      v2         <= v1;
      l2         <= l1;
      v3         <= v2;
      frame_done <= v2 && l2;
      if (issue) begin
        p[0] <= smul(k[0], w1);
        p[1] <= smul(k[1], w2);
        p[2] <= smul(k[2], w3);
        p[3] <= smul(k[3], w4);
      end
      if (v1) begin
        acc <= ACC_W'(p[0]) + ACC_W'(p[1]) + ACC_W'(p[2]) + ACC_W'(p[3])
             + (ACC_W'(bias) <<< FRAC);
      end
      if (v2) out_data <= sat;
    end
  end

  q_sat_shift #(.FRAC(FRAC)) u_sat (
    .din  (acc),
    .dout (sat)
  );

endmodule

// File: tb/tb_conv2x2_window_mac.sv
// Bench for conv2x2_window_mac on a 4x3 frame: constant vectors, random
// frames with enable gaps, weight writes during RUN, latency and mid-frame reset.
module tb_conv2x2_window_mac;
  import conv_pkg::*;

  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int FRAC  = 16;
  localparam int N_OUT = (IMG_W - 1) * (IMG_H - 1);

  typedef struct packed {
    logic [3:0][31:0] k;
    logic [31:0]      b;
    logic [3:0][31:0] w;
    logic [31:0]      e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        lf_done;
  logic [31:0] w1, w2, w3, w4;
  logic        wt_valid;
  logic [2:0]  wt_idx;
  logic [31:0] wt_data;
  logic        wt_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        frame_done;
  state_t      state;

  int tests  = 0;
  int failed = 0;
  int n_valid = 0;
  int n_done  = 0;

  logic [31:0] exp_q[$];
  logic        last_q[$];
  logic [31:0] mk [4];
  logic [31:0] mb;
  logic [31:0] mon_e;
  logic        mon_l;
  vec_t        vecs [7];

  conv2x2_window_mac #(.IMG_W(IMG_W), .IMG_H(IMG_H), .FRAC(FRAC)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .lf_done    (lf_done),
    .w1         (w1),
    .w2         (w2),
    .w3         (w3),
    .w4         (w4),
    .wt_valid   (wt_valid),
    .wt_idx     (wt_idx),
    .wt_data    (wt_data),
    .wt_ready   (wt_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .state      (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact wide arithmetic, floor rescale, clamp.
  function automatic logic [31:0] model(input logic [3:0][31:0] w);
    logic signed [127:0] acc;
    logic signed [127:0] q;
    acc = 128'(signed'(mb)) * 128'sd65536;
    for (int i = 0; i < 4; i++) acc = acc + 128'(signed'(mk[i])) * 128'(signed'(w[i]));
    q = acc >>> FRAC;
    if (q > 128'sd2147483647) return 32'h7FFF_FFFF;
    if (q < -128'sd2147483648) return 32'h8000_0000;
    return q[31:0];
  endfunction

  function automatic logic [3:0][31:0] rand_w();
    logic [3:0][31:0] w;
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    return w;
  endfunction

  function automatic vec_t mk_vec(input logic [3:0][31:0] k, input logic [31:0] b,
                                  input logic [3:0][31:0] w, input logic [31:0] e);
    vec_t v;
    v.k = k; v.b = b; v.w = w; v.e = e;
    return v;
  endfunction

  // Scoreboard monitor: sampled on the falling edge.
  always @(negedge clk) begin
    if (frame_done) n_done++;
    if (out_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_out: got %h with no expected result queued", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        mon_l = last_q.pop_front();
        check("out_data", out_data, mon_e);
        check("frame_done_with_last", 32'(frame_done), 32'(mon_l));
      end
    end else if (frame_done) begin
      tests++;
      failed++;
      $display("FAIL frame_done_alone: got 1 expected 0 without out_valid");
    end
  end

  task automatic drive(input logic en, input logic lf, input logic [3:0][31:0] w, input bit spam);
    enable  = en;
    lf_done = lf;
    w1 = w[0]; w2 = w[1]; w3 = w[2]; w4 = w[3];
    wt_valid = spam;
    wt_idx   = 3'($urandom_range(0, 7));
    wt_data  = $urandom;
    @(negedge clk);
    wt_valid = 1'b0;
  endtask

  task automatic write_weights(input logic [3:0][31:0] k, input logic [31:0] b);
    for (int i = 0; i < 5; i++) begin
      wt_valid = 1'b1;
      wt_idx   = 3'(i);
      wt_data  = (i < 4) ? k[i] : b;
      @(negedge clk);
    end
    for (int i = 5; i < 8; i++) begin
      wt_valid = 1'b1;
      wt_idx   = 3'(i);
      wt_data  = $urandom;
      @(negedge clk);
    end
    wt_valid = 1'b0;
    for (int i = 0; i < 4; i++) mk[i] = k[i];
    mb = b;
  endtask

  task automatic run_frame(input bit fixed, input logic [3:0][31:0] fw, input logic [31:0] fexp,
                           input bit gaps, input bit spam);
    logic [3:0][31:0] w;
    int t;
    n_valid = 0;
    n_done  = 0;
    drive(1'b1, 1'b0, rand_w(), 1'b0);
    drive(1'b1, 1'b0, rand_w(), 1'b0);
    drive(1'b1, 1'b1, rand_w(), spam);
    check("wt_ready_in_run", 32'(wt_ready), 32'd0);
    for (int r = 1; r < IMG_H; r++) begin
      for (int c = (r == 1) ? 1 : 0; c < IMG_W; c++) begin
        if (gaps) repeat ($urandom_range(0, 2)) drive(1'b0, 1'($urandom_range(0, 1)), rand_w(), spam);
        w = fixed ? fw : rand_w();
        if (c != 0) begin
          exp_q.push_back(fixed ? fexp : model(w));
          last_q.push_back(r == IMG_H - 1 && c == IMG_W - 1);
        end
        drive(1'b1, 1'($urandom_range(0, 1)), w, spam);
      end
    end
    drive(1'b1, 1'b1, rand_w(), 1'b0);
    drive(1'b1, 1'b1, rand_w(), 1'b0);
    enable  = 1'b0;
    lf_done = 1'b0;
    t = 0;
    while (state != IDLE && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("drain_to_idle", 32'(state), 32'(IDLE));
    repeat (2) @(negedge clk);
    check("valid_count", 32'(n_valid), 32'(N_OUT));
    check("frame_done_count", 32'(n_done), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    #2;
    reset    = 1'b0;
    enable   = 1'b0;
    lf_done  = 1'b0;
    wt_valid = 1'b0;
    exp_q.delete();
    last_q.delete();
    for (int i = 0; i < 4; i++) mk[i] = '0;
    mb = '0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_wt_ready", 32'(wt_ready), 32'd1);
    check("rst_state", 32'(state), 32'(IDLE));
    @(negedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0][31:0] one4;
    int lat;
    one4 = {4{32'h0001_0000}};
    vecs[0] = mk_vec(one4, 32'h0, one4, 32'h0004_0000);
    vecs[1] = mk_vec({32'h0, 32'h0, 32'h0, 32'h0001_8000}, 32'h0,
                     {32'h0, 32'h0, 32'h0, 32'hFFFE_0000}, 32'hFFFD_0000);
    vecs[2] = mk_vec({4{32'h7FFF_FFFF}}, 32'h0, {4{32'h7FFF_FFFF}}, 32'h7FFF_FFFF);
    vecs[3] = mk_vec({4{32'h8000_0000}}, 32'h0, {4{32'h7FFF_FFFF}}, 32'h8000_0000);
    vecs[4] = mk_vec({4{32'h0}}, 32'h0002_0000, {32'h5, 32'h77, 32'h1234_5678, 32'hDEAD_BEEF},
                     32'h0002_0000);
    vecs[5] = mk_vec({32'h0, 32'h0, 32'h0, 32'h0000_8000}, 32'h0,
                     {32'h0, 32'h0, 32'h0, 32'hFFFF_0001}, 32'hFFFF_8000);
    vecs[6] = mk_vec(one4, 32'hFFFF_0000, {32'h0, 32'hFFFF_0000, 32'h0002_0000, 32'h0001_0000},
                     32'h0001_0000);

    reset    = 1'b0;
    enable   = 1'b0;
    lf_done  = 1'b0;
    w1 = '0; w2 = '0; w3 = '0; w4 = '0;
    wt_valid = 1'b0;
    wt_idx   = '0;
    wt_data  = '0;
    for (int i = 0; i < 4; i++) mk[i] = '0;
    mb = '0;
    repeat (2) @(negedge clk);
    check("init_out_valid", 32'(out_valid), 32'd0);
    check("init_out_data", out_data, 32'd0);
    check("init_wt_ready", 32'(wt_ready), 32'd1);
    check("init_state", 32'(state), 32'(IDLE));
    reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      write_weights(vecs[v].k, vecs[v].b);
      run_frame(1'b1, vecs[v].w, vecs[v].e, 1'b0, 1'b0);
    end

    write_weights(rand_w(), $urandom);
    run_frame(1'b0, '0, '0, 1'b1, 1'b0);
    run_frame(1'b0, '0, '0, 1'b1, 1'b1);
    run_frame(1'b0, '0, '0, 1'b0, 1'b0);

    write_weights(one4, 32'h0);
    drive(1'b1, 1'b0, rand_w(), 1'b0);
    drive(1'b1, 1'b1, rand_w(), 1'b0);
    exp_q.push_back(32'h0004_0000);
    last_q.push_back(1'b0);
    drive(1'b1, 1'b0, one4, 1'b0);
    lat = 1;
    while (!out_valid && lat < 10) begin
      drive(1'b0, 1'b0, '0, 1'b0);
      lat++;
    end
    check("latency_cycles", 32'(lat), 32'd3);
    exp_q.push_back(32'h0004_0000);
    last_q.push_back(1'b0);
    drive(1'b1, 1'b0, one4, 1'b0);
    do_reset();
    run_frame(1'b0, '0, '0, 1'b0, 1'b0);
    run_frame(1'b0, '0, '0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/conv2x2_window_mac.md
CONV2X2_WINDOW_MAC -- requirements
Module: conv2x2_window_mac

Interface
REQ-001 Parameter IMG_W, 32, pixels per image row (>=2).
REQ-002 Parameter IMG_H, 32, rows per frame (>=2).
REQ-003 Parameter FRAC, 16, fractional bits of signed fixed-point data (Q(31-FRAC).FRAC).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  a new pixel/window presented this cycle.
REQ-007 lf_done  input  1  line buffer filled; w1..w4 hold valid window data from now on.
REQ-008 w1, w2, w3, w4  input  32 each  2x2 window: w1 top-left, w2 top-right, w3 bottom-left, w4 bottom-right (newest).
REQ-009 wt_valid  input  1  weight/bias write strobe.
REQ-010 wt_idx  input  3  write target: 0..3 = k1..k4 (pairs with w1..w4), 4 = bias; 5..7 ignored.
REQ-011 wt_data  input  32  signed fixed-point weight/bias value.
REQ-012 wt_ready  output  1  high when weight writes are accepted.
REQ-013 out_data  output  32  signed fixed-point convolution result.
REQ-014 out_valid  output  1  out_data valid this cycle.
REQ-015 frame_done  output  1  one-cycle pulse with the last out_valid of a frame.

Function
REQ-016 The FSM SHALL have states IDLE, FILL, RUN, DRAIN; wt_ready=1 only in IDLE.
REQ-017 IDLE->FILL on first enable=1; FILL->RUN on the cycle lf_done=1 with enable=1; that window is coordinate (row 1, col 0).
REQ-018 In RUN, each enable=1 cycle SHALL advance col 0..IMG_W-1, wrapping to 0 and incrementing row; enable=0 freezes coordinates.
REQ-019 A window SHALL be issued to the pipeline only when state=RUN, enable=1 and col!=0 (row-straddling windows discarded).
REQ-020 After the window at (IMG_H-1, IMG_W-1) is accepted, RUN->DRAIN; DRAIN->IDLE once the pipeline is empty.
REQ-021 Pipeline: stage 1 registers four signed 32x32->64 products; stage 2 registers sum of products plus (bias << FRAC) at 67 bits; stage 3 arithmetic-shifts right by FRAC (truncate toward -inf) and saturates to [0x80000000, 0x7FFFFFFF].
REQ-022 Latency SHALL be exactly 3 cycles from issuing edge to out_valid; pipeline never stalls, throughput one window per cycle.
REQ-023 Exactly (IMG_W-1)*(IMG_H-1) out_valid pulses SHALL occur per frame; frame_done coincides with the last.
REQ-024 wt_valid in IDLE with wt_idx<=4 SHALL update the target register next edge; writes in other states or with idx 5..7 are ignored.
REQ-025 lf_done while in RUN/DRAIN SHALL be ignored; enable in DRAIN SHALL be ignored.
REQ-026 Weights/bias SHALL persist across frames until rewritten or reset.

Reset
REQ-027 reset=0 SHALL immediately force state IDLE, row/col 0, k1..k4 and bias 0, all pipeline registers and valids 0, out_data 0, out_valid 0, frame_done 0, wt_ready 1.
REQ-028 Reset mid-frame SHALL discard in-flight results; no out_valid or frame_done until a new frame reaches RUN.

Structure
REQ-029 Shared package conv_pkg SHALL hold FRAC default, data width 32, state encoding, wt_idx constants (K1..K4, BIAS), saturation limits.
REQ-030 Saturation/shift SHALL be a sub-module q_sat_shift (67-bit in, 32-bit out, combinational), instantiated in stage 3.

Verification
REQ-031 All k=0x00010000, bias 0, all w=0x00010000 -> out_data 0x00040000, out_valid 3 cycles after issue.
REQ-032 k1=0x00018000, w1=0xFFFE0000, other k=0 -> out_data 0xFFFD0000 (-3.0).
REQ-033 All k=0x7FFFFFFF, all w=0x7FFFFFFF -> 0x7FFFFFFF; k=0x80000000 with w=0x7FFFFFFF -> 0x80000000.
REQ-034 IMG_W=4, IMG_H=3, continuous enable -> exactly 6 out_valid pulses, none for col 0, frame_done with 6th; same with random enable gaps.
REQ-035 reset=0 for one cycle mid-RUN -> out_valid 0 and weights 0 immediately, wt_ready 1; next full frame yields correct count.
REQ-036 wt_valid during RUN -> weights unchanged, results match pre-frame weights.
